// File: rtl/apb_reg_bank_pkg.sv
// Shared definitions for the APB register bank: register offsets, FSM states,
// interrupt bit positions and the byte-lane merge helper.
// No logic of its own; imported by apb_reg_bank and apb_reg_bank_cnt users.
package apb_reg_bank_pkg;

   // Register byte offsets; addr[1:0] is ignored by the decoder
   localparam logic [31:0] OFF_CTRL     = 32'h000;
   localparam logic [31:0] OFF_SCRATCH  = 32'h004;
   localparam logic [31:0] OFF_INT_STAT = 32'h008;
   localparam logic [31:0] OFF_INT_EN   = 32'h00C;
   localparam logic [31:0] OFF_COUNTER  = 32'h010;
   localparam logic [31:0] OFF_ID       = 32'h014;

   // INT_STAT / INT_EN bit positions
   localparam int INT_WRAP_BIT = 0;
   localparam int INT_EVT_BIT  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // Replace only the byte lanes whose enable is set
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_reg_bank_cnt.sv
// 32-bit free-running counter with enable, synchronous clear and wrap pulse.
// Latency: clear/increment land on the next pclk edge; wrap_o is high in the wrap cycle.
// Backpressure: none; en_i simply gates counting, clr_i beats en_i.
module apb_reg_bank_cnt (
   input  logic        pclk,
   input  logic        prst_n,
   input  logic        en_i,
   input  logic        clr_i,
   output logic [31:0] cnt_o,
   output logic        wrap_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // Clear has priority; the increment wraps naturally through 32 bits
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 32'd1;
   end

   // Counter state register
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = en_i & ~clr_i & (cnt_q == 32'hFFFF_FFFF);

endmodule

// File: rtl/apb_reg_bank.sv
// Register bank behind the APB slave: CTRL, SCRATCH, INT_STAT/INT_EN, COUNTER, ID; drives irq.
// Latency: request seen in cycle N -> ready in cycle N+2+WAIT_CYCLES; writes commit as RESP ends.
// Backpressure: rd/wr are held until the one-cycle ready; APB_REG_BANK_COUNTER_EN adds the counter.
module apb_reg_bank #(
   parameter int          ADDR_WIDTH  = 12,
   parameter int          DATA_WIDTH  = 32,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [27:0] ID_VALUE    = 28'h0A5B001
) (
   input  logic                  pclk,
   input  logic                  prst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rd,
   input  logic                  wr,
   input  logic [3:0]            strb,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [3:0]            ecorevnum,
   input  logic                  event_in,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  slverr,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] ctrl_out
);
   import apb_reg_bank_pkg::*;

`ifdef APB_REG_BANK_COUNTER_EN
   localparam logic [1:0] INT_MASK = 2'b11;
`else
   localparam logic [1:0] INT_MASK = 2'b10;
`endif

   state_e                state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-3:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            strb_q;
   logic                  rd_q, wr_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  slverr_q;
   logic                  irq_q;
   logic [31:0]           ctrl_q, ctrl_d;
   logic [31:0]           scratch_q, scratch_d;
   logic [1:0]            int_stat_q, int_stat_d;
   logic [1:0]            int_en_q, int_en_d;
   logic [1:0]            int_set;

   logic [ADDR_WIDTH-1:0] addr_al;
   logic                  hit_ctrl, hit_scr, hit_stat, hit_en, hit_cnt, hit_id;
   logic                  start, capture, commit, xfer_err;
   logic [31:0]           rd_val;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = ^addr[1:0];

   assign start   = (state_q == IDLE) & (rd | wr);
   assign capture = (state_q == BUSY) & (wcnt_q == 4'd0);
   // slverr_q is the captured error flag and is only set during RESP
   assign commit  = (state_q == RESP) & wr_q & ~slverr_q;

   // Decode of the captured, word-aligned address
   assign addr_al  = {addr_q, 2'b00};
   assign hit_ctrl = (addr_al == ADDR_WIDTH'(OFF_CTRL));
   assign hit_scr  = (addr_al == ADDR_WIDTH'(OFF_SCRATCH));
   assign hit_stat = (addr_al == ADDR_WIDTH'(OFF_INT_STAT));
   assign hit_en   = (addr_al == ADDR_WIDTH'(OFF_INT_EN));
   assign hit_id   = (addr_al == ADDR_WIDTH'(OFF_ID));

`ifdef APB_REG_BANK_COUNTER_EN
   logic [31:0] cnt_val;
   logic        cnt_wrap;
   logic        cnt_clr;

   assign hit_cnt = (addr_al == ADDR_WIDTH'(OFF_COUNTER));
   // cnt_clr is a write-1 pulse on CTRL[1]; it never lands in ctrl_q
   assign cnt_clr = commit & hit_ctrl & strb_q[0] & wdata_q[1];

   apb_reg_bank_cnt u_cnt (
      .pclk   (pclk),
      .prst_n (prst_n),
      .en_i   (ctrl_q[0]),
      .clr_i  (cnt_clr),
      .cnt_o  (cnt_val),
      .wrap_o (cnt_wrap)
   );

   assign int_set = {event_in, cnt_wrap};
`else
   assign hit_cnt = 1'b0;
   assign int_set = {event_in, 1'b0};
`endif

   // Bad address, write to a read-only register, or rd and wr together
   assign xfer_err = (rd_q & wr_q)
                   | ~(hit_ctrl | hit_scr | hit_stat | hit_en | hit_cnt | hit_id)
                   | (wr_q & (hit_cnt | hit_id));

   // Read mux over the captured address
   always_comb begin
      rd_val = '0;
      if (hit_ctrl) rd_val = ctrl_q;
      if (hit_scr)  rd_val = scratch_q;
      if (hit_stat) rd_val = {30'd0, int_stat_q};
      if (hit_en)   rd_val = {30'd0, int_en_q};
      if (hit_id)   rd_val = {ID_VALUE, ecorevnum};
`ifdef APB_REG_BANK_COUNTER_EN
      if (hit_cnt)  rd_val = cnt_val;
`endif
   end

   // FSM next state: IDLE -> BUSY (wait states) -> RESP -> IDLE
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         IDLE: begin
            if (rd | wr) begin
               state_d = BUSY;
               wcnt_d  = 4'(WAIT_CYCLES);
            end
         end
         BUSY: begin
            if (wcnt_q == 4'd0) state_d = RESP;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state and wait-state counter
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Request capture in IDLE; later changes on the bus are ignored
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else if (start) begin
         addr_q  <= addr[ADDR_WIDTH-1:2];
         wdata_q <= wdata;
         strb_q  <= strb;
         rd_q    <= rd;
         wr_q    <= wr;
      end
   end

   // Response capture on BUSY->RESP; rdata holds until the next capture
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         rdata_q  <= '0;
         slverr_q <= 1'b0;
      end else if (capture) begin
         rdata_q  <= xfer_err ? '0 : rd_val;
         slverr_q <= xfer_err;
      end else if (state_q == RESP) begin
         slverr_q <= 1'b0;
      end
   end

   // Register next state; hardware interrupt set is applied after W1C so set wins
   always_comb begin
      ctrl_d     = ctrl_q;
      scratch_d  = scratch_q;
      int_en_d   = int_en_q;
      int_stat_d = int_stat_q;
      if (commit & hit_ctrl) ctrl_d    = merge_bytes(ctrl_q, wdata_q, strb_q);
      if (commit & hit_scr)  scratch_d = merge_bytes(scratch_q, wdata_q, strb_q);
      if (commit & hit_en & strb_q[0])   int_en_d   = wdata_q[1:0] & INT_MASK;
      if (commit & hit_stat & strb_q[0]) int_stat_d = int_stat_q & ~wdata_q[1:0];
      int_stat_d = (int_stat_d | int_set) & INT_MASK;
`ifdef APB_REG_BANK_COUNTER_EN
      ctrl_d[1] = 1'b0;
`endif
   end

   // Register file and registered interrupt output
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         ctrl_q     <= '0;
         scratch_q  <= '0;
         int_stat_q <= '0;
         int_en_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         scratch_q  <= scratch_d;
         int_stat_q <= int_stat_d;
         int_en_q   <= int_en_d;
         irq_q      <= |(int_stat_q & int_en_q);
      end
   end

   assign ready    = (state_q == RESP);
   assign rdata    = rdata_q;
   assign slverr   = slverr_q;
   assign irq      = irq_q;
   assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: directed vector table, hand-written corner sequences,
// then randomized transfers checked against a register-map model.
// All stimulus is driven and all outputs sampled on the falling clock edge.
module tb_apb_reg_bank;

`ifdef APB_REG_BANK_COUNTER_EN
   localparam bit         HAS_CNT = 1'b1;
   localparam logic [1:0] EN_MASK = 2'b11;
`else
   localparam bit         HAS_CNT = 1'b0;
   localparam logic [1:0] EN_MASK = 2'b10;
`endif
   localparam logic [31:0] ID_EXP  = 32'h0A5B_0017;
   localparam int          LAT_EXP = 3;

   logic        pclk = 1'b0;
   logic        prst_n;
   logic [11:0] addr;
   logic        rd, wr;
   logic [3:0]  strb;
   logic [31:0] wdata;
   logic [3:0]  ecorevnum;
   logic        event_in;
   logic [31:0] rdata;
   logic        ready, slverr, irq;
   logic [31:0] ctrl_out;

   int n_chk  = 0;
   int n_pass = 0;

   apb_reg_bank #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(1), .ID_VALUE(28'h0A5B001)
   ) dut (
      .pclk(pclk), .prst_n(prst_n), .addr(addr), .rd(rd), .wr(wr), .strb(strb),
      .wdata(wdata), .ecorevnum(ecorevnum), .event_in(event_in), .rdata(rdata),
      .ready(ready), .slverr(slverr), .irq(irq), .ctrl_out(ctrl_out)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
   endtask

   // One transfer; returns at the falling edge where ready is high (rd/wr dropped there)
   task automatic xfer(input logic do_rd, input logic do_wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit evt_at_resp,
                       output logic [31:0] rdat, output logic err, output int lat);
      @(negedge pclk);
      addr = a; rd = do_rd; wr = do_wr; wdata = d; strb = s;
      lat = 0; rdat = '0; err = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge pclk);
         // bus changes after capture must not matter
         addr = 12'($urandom); wdata = $urandom; strb = 4'($urandom);
         if (ready) begin
            lat = k;
            break;
         end
      end
      rdat = rdata; err = slverr;
      rd = 1'b0; wr = 1'b0;
      if (lat == 0) begin
         n_chk++;
         $display("FAIL timeout: no ready for addr %03h within 20 cycles", a);
      end
      if (evt_at_resp) begin
         event_in = 1'b1;
         @(negedge pclk);
         event_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge pclk);
      prst_n = 1'b0; rd = 1'b0; wr = 1'b0; event_in = 1'b0;
      repeat (2) @(negedge pclk);
      prst_n = 1'b1;
   endtask

   typedef struct {
      logic        do_rd;
      logic        do_wr;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vt[$];

   task automatic add(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input logic ee);
      vec_t v;
      v.do_rd = r; v.do_wr = w; v.a = a; v.d = d; v.s = s; v.exp_rd = er; v.exp_err = ee;
      vt.push_back(v);
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   logic [31:0] r_dat;
   logic        r_err;
   int          r_lat;
   logic [31:0] m_ctrl, m_scr;
   logic [1:0]  m_stat, m_en;

   initial begin
      prst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; strb = '0; wdata = '0;
      ecorevnum = 4'h7; event_in = 1'b0;
      repeat (3) @(negedge pclk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_slverr", {31'd0, slverr}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_ctrl", ctrl_out, 32'd0);
      prst_n = 1'b1;

      // Directed vector table: rd, wr, addr, wdata, strb, expected rdata, expected slverr
      add(0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
      add(1, 0, 12'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
      add(0, 1, 12'h004, 32'h11223344, 4'h5, 32'h0,        1'b0);
      add(1, 0, 12'h004, 32'h0,        4'h0, 32'hDE22BE44, 1'b0);
      add(1, 0, 12'h020, 32'h0,        4'h0, 32'h0,        1'b1);
      add(0, 1, 12'h014, 32'h12345678, 4'hF, 32'h0,        1'b1);
      add(1, 0, 12'h014, 32'h0,        4'h0, ID_EXP,       1'b0);
      add(0, 1, 12'h004, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
      add(1, 0, 12'h007, 32'h0,        4'h0, 32'hDE22BE44, 1'b0);
      add(0, 1, 12'h000, 32'hA5A55AF0, 4'hF, 32'h0,        1'b0);
      add(1, 0, 12'h000, 32'h0,        4'h0, 32'hA5A55AF0, 1'b0);
      add(1, 0, 12'h010, 32'h0,        4'h0, 32'h0,        !HAS_CNT);
      add(0, 1, 12'h010, 32'h1,        4'hF, 32'h0,        1'b1);
      add(0, 1, 12'h00C, 32'hFFFFFFFF, 4'h1, 32'h0,        1'b0);
      add(1, 0, 12'h00C, 32'h0,        4'h0, {30'd0, EN_MASK}, 1'b0);
      add(1, 1, 12'h004, 32'h0,        4'hF, 32'h0,        1'b1);
      add(1, 0, 12'h004, 32'h0,        4'h0, 32'hDE22BE44, 1'b0);
      add(1, 0, 12'h008, 32'h0,        4'h0, 32'h0,        1'b0);

      foreach (vt[i]) begin
         xfer(vt[i].do_rd, vt[i].do_wr, vt[i].a, vt[i].d, vt[i].s, 1'b0, r_dat, r_err, r_lat);
         chk($sformatf("vec%0d_lat", i), r_lat, LAT_EXP);
         chk($sformatf("vec%0d_err", i), {31'd0, r_err}, {31'd0, vt[i].exp_err});
         if (vt[i].do_rd) chk($sformatf("vec%0d_rdata", i), r_dat, vt[i].exp_rd);
      end
      chk("ctrl_out", ctrl_out, 32'hA5A55AF0);

      // Event pulse sets INT_STAT[1]; irq follows one cycle later
      @(negedge pclk); event_in = 1'b1;
      @(negedge pclk); event_in = 1'b0;
      chk("evt_irq_early", {31'd0, irq}, 32'd0);
      @(negedge pclk);
      chk("evt_irq", {31'd0, irq}, 32'd1);
      xfer(1, 0, 12'h008, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("evt_stat", r_dat, 32'h2);

      // W1C of bit 1 in the same cycle as a new event: set wins
      xfer(0, 1, 12'h008, 32'h2, 4'hF, 1'b1, r_dat, r_err, r_lat);
      xfer(1, 0, 12'h008, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("setwin_stat", r_dat, 32'h2);
      chk("setwin_irq", {31'd0, irq}, 32'd1);

      // Plain W1C: ready lasts one cycle, irq drops two cycles after RESP
      xfer(0, 1, 12'h008, 32'h2, 4'hF, 1'b0, r_dat, r_err, r_lat);
      @(negedge pclk);
      chk("ready_one_cycle", {31'd0, ready}, 32'd0);
      chk("w1c_irq_hold", {31'd0, irq}, 32'd1);
      @(negedge pclk);
      chk("w1c_irq_clr", {31'd0, irq}, 32'd0);
      xfer(1, 0, 12'h008, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("w1c_stat", r_dat, 32'h0);

`ifdef APB_REG_BANK_COUNTER_EN
      // Counter wrap sets INT_STAT[0] and raises irq
      xfer(0, 1, 12'h000, 32'h1, 4'hF, 1'b0, r_dat, r_err, r_lat);
      @(negedge pclk);
      force dut.u_cnt.cnt_q = 32'hFFFF_FFF8;
      @(negedge pclk);
      release dut.u_cnt.cnt_q;
      repeat (14) @(negedge pclk);
      xfer(1, 0, 12'h008, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("wrap_stat", r_dat, 32'h1);
      chk("wrap_irq", {31'd0, irq}, 32'd1);
      xfer(0, 1, 12'h008, 32'h1, 4'hF, 1'b0, r_dat, r_err, r_lat);
      @(negedge pclk);
      chk("wrap_irq_hold", {31'd0, irq}, 32'd1);
      @(negedge pclk);
      chk("wrap_irq_clr", {31'd0, irq}, 32'd0);
      xfer(0, 1, 12'h000, 32'hA5A55AF2, 4'hF, 1'b0, r_dat, r_err, r_lat);
      xfer(1, 0, 12'h010, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("cnt_after_clr", r_dat, 32'h0);
`endif

      // Reset while a SCRATCH write sits in BUSY: nothing commits
      @(negedge pclk);
      addr = 12'h004; wr = 1'b1; wdata = 32'h0BADF00D; strb = 4'hF;
      @(negedge pclk);
      prst_n = 1'b0;
      #1;
      chk("busyrst_ready", {31'd0, ready}, 32'd0);
      chk("busyrst_slverr", {31'd0, slverr}, 32'd0);
      chk("busyrst_rdata", rdata, 32'd0);
      chk("busyrst_ctrl", ctrl_out, 32'd0);
      @(negedge pclk);
      wr = 1'b0;
      chk("busyrst_ready2", {31'd0, ready}, 32'd0);
      prst_n = 1'b1;
      xfer(1, 0, 12'h004, 32'h0, 4'h0, 1'b0, r_dat, r_err, r_lat);
      chk("busyrst_scratch", r_dat, 32'h0);
      chk("busyrst_lat", r_lat, LAT_EXP);

      // Randomized transfers against a register-map model
      do_reset();
      m_ctrl = '0; m_scr = '0; m_stat = '0; m_en = '0;
      for (int t = 0; t < 150; t++) begin
         int          w, op;
         logic        do_rd, do_wr, e_err, mapped;
         logic [11:0] a;
         logic [31:0] d, e_rd;
         logic [3:0]  s;
         w = $urandom_range(0, 7);
         if (w > 5) w = $urandom_range(6, 1023);
         if (HAS_CNT && w == 4) w = 1;
         a = {w[9:0], 2'($urandom)};
         op = $urandom_range(0, 9);
         do_rd = (op == 0) || (op > 4);
         do_wr = (op <= 4);
         d = $urandom;
         if (w == 0) d = d & ~32'h3;
         s = 4'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge pclk); event_in = 1'b1;
            @(negedge pclk); event_in = 1'b0;
            m_stat[1] = 1'b1;
         end
         mapped = (w <= 5) && !(w == 4 && !HAS_CNT);
         e_err  = (do_rd && do_wr) || !mapped || (do_wr && (w == 4 || w == 5));
         case (w)
            0:       e_rd = m_ctrl;
            1:       e_rd = m_scr;
            2:       e_rd = {30'd0, m_stat};
            3:       e_rd = {30'd0, m_en};
            5:       e_rd = ID_EXP;
            default: e_rd = 32'd0;
         endcase
         if (e_err) e_rd = 32'd0;
         xfer(do_rd, do_wr, a, d, s, 1'b0, r_dat, r_err, r_lat);
         chk($sformatf("rnd%0d_lat", t), r_lat, LAT_EXP);
         chk($sformatf("rnd%0d_err", t), {31'd0, r_err}, {31'd0, e_err});
         if (do_rd) chk($sformatf("rnd%0d_rdata", t), r_dat, e_rd);
         chk($sformatf("rnd%0d_irq", t), {31'd0, irq}, {31'd0, |(m_stat & m_en)});
         if (do_wr && !e_err) begin
            case (w)
               0: m_ctrl = lanes(m_ctrl, d, s);
               1: m_scr  = lanes(m_scr, d, s);
               2: if (s[0]) m_stat = m_stat & ~d[1:0];
               3: if (s[0]) m_en = d[1:0] & EN_MASK;
               default: ;
            endcase
         end
      end
      @(negedge pclk);
      chk("rnd_ctrl_out", ctrl_out, m_ctrl);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
